// File: rtl/mem_arbiter.sv
// Two-requester memory port arbiter (IFU fetch / LSU data) with one outstanding
// transaction and a response watchdog. Define MEM_ARB_RR_EN for round-robin grant.
module mem_arbiter #(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = 9
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [XLEN-1:0] ifu_req_addr,
  output logic            ifu_rsp_valid,
  output logic [XLEN-1:0] ifu_rsp_rdata,
  output logic            ifu_rsp_err,
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic            lsu_req_wen,
  input  logic [XLEN-1:0] lsu_req_addr,
  input  logic [3:0]      lsu_req_wstrb,
  input  logic [XLEN-1:0] lsu_req_wdata,
  output logic            lsu_rsp_valid,
  output logic [XLEN-1:0] lsu_rsp_rdata,
  output logic            lsu_rsp_err,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_wen,
  output logic [XLEN-1:0] mem_req_addr,
  output logic [3:0]      mem_req_wstrb,
  output logic [XLEN-1:0] mem_req_wdata,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_rdata
);

  // state  | meaning
  // S_IDLE | accept one request from the granted requester
  // S_REQ  | buffered request presented downstream until mem_req_ready
  // S_RSP  | wait for mem_rsp_valid or watchdog expiry, route back to owner
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} state_t;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;
  localparam bit   TO_EN   = (TIMEOUT_CYC > 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EN ? TIMEOUT_CYC - 1 : 0);

  state_t            state_q;
  logic              owner_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [3:0]        wstrb_q;
  logic              wen_q;

  logic grant_lsu, grant_ifu, accept, in_rsp, timeout, rsp_fire;
  logic [XLEN-1:0] rdata_out;

`ifdef MEM_ARB_RR_EN
  logic last_grant_q;

  // On contention, the requester that did not win last time goes first.
  assign grant_lsu = lsu_req_valid && (!ifu_req_valid || (last_grant_q == OWN_IFU));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      last_grant_q <= OWN_IFU;
    end else if (accept) begin
      last_grant_q <= grant_lsu ? OWN_LSU : OWN_IFU;
    end
  end
`else
  // Data access of an older instruction completes before the next fetch.
  assign grant_lsu = lsu_req_valid;
`endif

  assign grant_ifu     = ifu_req_valid && !grant_lsu;
  assign ifu_req_ready = (state_q == S_IDLE) && grant_ifu;
  assign lsu_req_ready = (state_q == S_IDLE) && grant_lsu;
  assign accept        = ifu_req_ready || lsu_req_ready;

  assign in_rsp   = (state_q == S_RSP);
  assign timeout  = TO_EN && in_rsp && !mem_rsp_valid && (cnt_q == TO_LAST);
  assign rsp_fire = in_rsp && (mem_rsp_valid || timeout);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      owner_q <= OWN_IFU;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      wen_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q <= S_REQ;
            owner_q <= grant_lsu ? OWN_LSU : OWN_IFU;
            if (grant_lsu) begin
              addr_q  <= lsu_req_addr;
              wdata_q <= lsu_req_wdata;
              wstrb_q <= lsu_req_wstrb;
              wen_q   <= lsu_req_wen;
            end else begin
              addr_q  <= ifu_req_addr;
              wdata_q <= '0;
              wstrb_q <= 4'hF;
              wen_q   <= 1'b0;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            state_q <= S_RSP;
            cnt_q   <= '0;
          end
        end
        S_RSP: begin
          if (rsp_fire) begin
            state_q <= S_IDLE;
          end else if (TO_EN) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_wen   = wen_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wstrb = wstrb_q;
  assign mem_req_wdata = wdata_q;

  // Writes and watchdog errors return zero data.
  assign rdata_out = (in_rsp && mem_rsp_valid && !wen_q) ? mem_rsp_rdata : '0;

  assign ifu_rsp_valid = rsp_fire && (owner_q == OWN_IFU);
  assign ifu_rsp_rdata = (owner_q == OWN_IFU) ? rdata_out : '0;
  assign ifu_rsp_err   = timeout && (owner_q == OWN_IFU);
  assign lsu_rsp_valid = rsp_fire && (owner_q == OWN_LSU);
  assign lsu_rsp_rdata = (owner_q == OWN_LSU) ? rdata_out : '0;
  assign lsu_rsp_err   = timeout && (owner_q == OWN_LSU);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4-cycle watchdog; expectations follow
// fixed priority unless MEM_ARB_RR_EN is defined.
module tb_mem_arbiter;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_b;
  logic            ifu_req_valid, ifu_req_ready;
  logic [XLEN-1:0] ifu_req_addr;
  logic            ifu_rsp_valid, ifu_rsp_err;
  logic [XLEN-1:0] ifu_rsp_rdata;
  logic            lsu_req_valid, lsu_req_ready, lsu_req_wen;
  logic [XLEN-1:0] lsu_req_addr, lsu_req_wdata;
  logic [3:0]      lsu_req_wstrb;
  logic            lsu_rsp_valid, lsu_rsp_err;
  logic [XLEN-1:0] lsu_rsp_rdata;
  logic            mem_req_valid, mem_req_ready, mem_req_wen;
  logic [XLEN-1:0] mem_req_addr, mem_req_wdata;
  logic [3:0]      mem_req_wstrb;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_rdata;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.XLEN(XLEN), .TIMEOUT_CYC(4), .CNT_W(9)) dut (
    .clk(clk), .rst_b(rst_b),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_rdata(ifu_rsp_rdata), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_wen(lsu_req_wen),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wstrb(lsu_req_wstrb), .lsu_req_wdata(lsu_req_wdata),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata), .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr), .mem_req_wstrb(mem_req_wstrb), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic all_outputs_zero(input string tag);
    chk({tag, "_outs"},
        {ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, lsu_req_ready, lsu_rsp_valid,
         lsu_rsp_err, mem_req_valid, mem_req_wen, mem_req_wstrb},
        '0);
    chk({tag, "_data"}, {ifu_rsp_rdata, lsu_rsp_rdata}, '0);
    chk({tag, "_mreq"}, {mem_req_addr, mem_req_wdata}, '0);
  endtask

  // One contended round: both requesters held valid, winner served with a read.
  task automatic round(input bit exp_lsu, input string tag);
    settle();
    chk({tag, "_ready"}, {lsu_req_ready, ifu_req_ready}, exp_lsu ? 2'b10 : 2'b01);
    cyc();
    mem_req_ready = 1'b1;
    settle();
    chk({tag, "_addr"}, mem_req_addr, exp_lsu ? 32'h8000_2000 : 32'h8000_0010);
    cyc();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'hA5A5_0001;
    settle();
    chk({tag, "_rsp"}, {lsu_rsp_valid, ifu_rsp_valid}, exp_lsu ? 2'b10 : 2'b01);
    cyc();
    mem_rsp_valid = 1'b0;
  endtask

  initial begin
    bit exp2_lsu;
    rst_b = 1'b0;
    ifu_req_valid = 0; ifu_req_addr = '0;
    lsu_req_valid = 0; lsu_req_wen = 0; lsu_req_addr = '0; lsu_req_wstrb = '0; lsu_req_wdata = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = '0;
    cyc();
    cyc();
    settle();
    all_outputs_zero("reset");
    cyc();
    rst_b = 1'b1;

    // 1: IFU read alone
    cyc();
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_0000;
    settle();
    chk("t1_ready", {ifu_req_ready, lsu_req_ready}, 2'b10);
    cyc();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    settle();
    chk("t1_mreq", {mem_req_valid, mem_req_wen, mem_req_wstrb, mem_req_addr},
        {1'b1, 1'b0, 4'hF, 32'h8000_0000});
    cyc();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h0010_0073;
    settle();
    chk("t1_rsp", {ifu_rsp_valid, ifu_rsp_err, lsu_rsp_valid, ifu_rsp_rdata},
        {1'b1, 1'b0, 1'b0, 32'h0010_0073});
    cyc();
    mem_rsp_valid = 1'b0;
    settle();
    chk("t1_pulse", {ifu_rsp_valid, mem_req_valid}, 2'b00);

    // 2: LSU write with 3 cycles of backpressure
    cyc();
    lsu_req_valid = 1'b1; lsu_req_wen = 1'b1; lsu_req_addr = 32'h8000_1004;
    lsu_req_wstrb = 4'h3; lsu_req_wdata = 32'hDEAD_BEEF;
    settle();
    chk("t2_ready", {lsu_req_ready, ifu_req_ready}, 2'b10);
    cyc();
    lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_wdata = '0; lsu_req_wstrb = '0;
    for (int i = 0; i < 4; i++) begin
      mem_req_ready = (i == 3);
      settle();
      chk($sformatf("t2_hold%0d", i),
          {mem_req_valid, mem_req_wen, mem_req_wstrb, mem_req_addr, mem_req_wdata},
          {1'b1, 1'b1, 4'h3, 32'h8000_1004, 32'hDEAD_BEEF});
      cyc();
    end
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h1234_5678;
    settle();
    chk("t2_rsp", {lsu_rsp_valid, lsu_rsp_err, ifu_rsp_valid, lsu_rsp_rdata},
        {1'b1, 1'b0, 1'b0, 32'h0});
    cyc();
    mem_rsp_valid = 1'b0;
    lsu_req_wen   = 1'b0;

    // 4: watchdog expiry, then a late response that must be dropped
    cyc();
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_3000;
    settle();
    chk("t4_ready", lsu_req_ready, 1'b1);
    cyc();
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    mem_rsp_rdata = 32'h5555_AAAA;
    cyc();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("t4_wait%0d", i), {lsu_rsp_valid, ifu_rsp_valid}, 2'b00);
      cyc();
    end
    settle();
    chk("t4_timeout", {lsu_rsp_valid, lsu_rsp_err, ifu_rsp_valid, lsu_rsp_rdata},
        {1'b1, 1'b1, 1'b0, 32'h0});
    cyc();
    settle();
    chk("t4_after", {lsu_rsp_valid, lsu_rsp_err, mem_req_valid}, 3'b000);
    cyc();
    mem_rsp_valid = 1'b1;
    settle();
    chk("t4_late", {lsu_rsp_valid, ifu_rsp_valid, mem_req_valid}, 3'b000);
    cyc();
    mem_rsp_valid = 1'b0;

    // 6: response in the same cycle the watchdog would fire
    cyc();
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0020;
    cyc();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    cyc();
    mem_req_ready = 1'b0;
    cyc();
    cyc();
    cyc();
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'hCAFE_F00D;
    settle();
    chk("t6_race", {ifu_rsp_valid, ifu_rsp_err, ifu_rsp_rdata}, {1'b1, 1'b0, 32'hCAFE_F00D});
    cyc();
    mem_rsp_valid = 1'b0;

    // 5: reset while waiting in RSP
    cyc();
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000;
    cyc();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    cyc();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'hBAD0_BAD0;
    #1;
    rst_b = 1'b0;
    #1;
    all_outputs_zero("t5_rst");
    cyc();
    rst_b = 1'b1;
    settle();
    chk("t5_stale", {ifu_rsp_valid, lsu_rsp_valid, mem_req_valid}, 3'b000);
    cyc();
    mem_rsp_valid = 1'b0;
    ifu_req_valid = 1'b1;
    settle();
    chk("t5_ready", ifu_req_ready, 1'b1);
    cyc();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    settle();
    chk("t5_mreq", {mem_req_valid, mem_req_addr}, {1'b1, 32'h8000_0000});
    cyc();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h0000_0013;
    settle();
    chk("t5_rsp", {ifu_rsp_valid, ifu_rsp_err, ifu_rsp_rdata}, {1'b1, 1'b0, 32'h0000_0013});
    cyc();
    mem_rsp_valid = 1'b0;

    // 3: two contended rounds; the last grant so far was IFU
`ifdef MEM_ARB_RR_EN
    exp2_lsu = 1'b0;
`else
    exp2_lsu = 1'b1;
`endif
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0010;
    lsu_req_valid = 1'b1; lsu_req_wen = 1'b0; lsu_req_addr = 32'h8000_2000;
    lsu_req_wstrb = 4'hF; lsu_req_wdata = '0;
    round(1'b1, "t3_r1");
    round(exp2_lsu, "t3_r2");
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single core memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU).
- Required by the multi-cycle core, which replaces the zero-latency combinational memory access with a handshaked bus.
- Supports one outstanding transaction at a time: accepts, forwards, waits for the response and routes it back to the owner.
- Includes a response-timeout watchdog so a hung memory cannot stall the core silently.

Parameters:
- XLEN, 32, data/address width.
- TIMEOUT_CYC, 256, cycles to wait in RSP before forcing an error response; 0 disables the watchdog.
- CNT_W, 9, width of the timeout counter; must hold TIMEOUT_CYC.

Ports:
- clk  in  1  clock.
- rst_b  in  1  asynchronous active-low reset.
- ifu_req_valid  in  1  fetch request.
- ifu_req_ready  out  1  fetch request accepted.
- ifu_req_addr  in  XLEN  fetch address.
- ifu_rsp_valid  out  1  fetch response, one-cycle pulse.
- ifu_rsp_rdata  out  XLEN  fetched instruction.
- ifu_rsp_err  out  1  fetch timed out.
- lsu_req_valid  in  1  data request.
- lsu_req_ready  out  1  data request accepted.
- lsu_req_wen  in  1  1 = write.
- lsu_req_addr  in  XLEN  data address.
- lsu_req_wstrb  in  4  byte strobes.
- lsu_req_wdata  in  XLEN  write data.
- lsu_rsp_valid  out  1  data response (read data or write ack), one-cycle pulse.
- lsu_rsp_rdata  out  XLEN  read data; 0 for writes.
- lsu_rsp_err  out  1  data access timed out.
- mem_req_valid  out  1  downstream request.
- mem_req_ready  in  1  downstream accepts request.
- mem_req_wen  out  1  write enable.
- mem_req_addr  out  XLEN  address.
- mem_req_wstrb  out  4  strobes.
- mem_req_wdata  out  XLEN  write data.
- mem_rsp_valid  in  1  downstream response.
- mem_rsp_rdata  in  XLEN  downstream read data.

Behaviour:
- Reset (asynchronous, active-low):
  - state = IDLE; owner = IFU; last_grant = IFU; timeout counter = 0; request buffer = 0.
  - All outputs 0; the outputs are derived from these registers, so none needs its own reset value.
- States:
  - IDLE: accept a request.
  - REQ: present the buffered request downstream.
  - RSP: wait for the downstream response.
- IDLE:
  - Grant is combinational; only the granted requester sees ready=1, and only in IDLE.
  - On accepted valid&ready, latch addr/wen/wstrb/wdata (IFU: wen=0, wstrb=4'hF, wdata=0) and owner, then go to REQ.
  - No request: stay in IDLE.
- REQ:
  - mem_req_valid=1; mem_req_* come from the buffer and stay stable until mem_req_ready.
  - On mem_req_ready: go to RSP and clear the counter.
- RSP:
  - Owner rsp_valid = mem_rsp_valid, combinational pass-through; rdata = mem_rsp_rdata (forced to 0 for writes); err=0; go to IDLE the same edge.
  - Non-owner rsp_valid stays 0.
- Timeout:
  - With TIMEOUT_CYC>0, the counter increments each RSP cycle without mem_rsp_valid.
  - When counter == TIMEOUT_CYC-1 and still no response: owner rsp_valid=1, err=1, rdata=0; go to IDLE.
  - mem_rsp_valid arriving in the same cycle as the timeout wins (normal response, err=0).
- A mem_rsp_valid arriving in IDLE or REQ is ignored, which includes a late response after a timeout.
- Minimum latency:
  - Accept at cycle N; mem_req_valid at N+1.
  - With mem_req_ready=1 at N+1 and mem_rsp_valid=1 at N+2, rsp_valid is at N+2.
  - The next accept is at N+3 at the earliest.
- Simultaneous requests: resolved by the arbitration policy (Optional Feature). The loser's valid is held by the requester; nothing is dropped.
- Reset mid-operation: the transaction is abandoned; no response is issued to either requester.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - When both requesters are valid, grant the one not equal to last_grant.
  - last_grant updates on every accept.
  - A single valid requester is always granted.
- Undefined: fixed priority, LSU over IFU, so an older instruction's data access completes before the next fetch. The last_grant register is not built.

Test Plan:
1. IFU read alone: ifu_req_addr=0x80000000, mem_req_ready=1 immediately, mem_rsp_rdata=0x00100073 one cycle later -> mem_req_valid one cycle after accept with mem_req_wen=0 and mem_req_wstrb=0xF; ifu_rsp_valid pulse with rdata 0x00100073, err=0; lsu_rsp_valid stays 0.
2. LSU write with backpressure: addr=0x80001004, wstrb=0x3, wdata=0xDEADBEEF; mem_req_ready held 0 for 3 cycles -> mem_req_* stable for all 4 REQ cycles; after the response, lsu_rsp_valid=1 with rdata=0.
3. Simultaneous IFU and LSU requests for two rounds:
   - Fixed priority: LSU, LSU.
   - MEM_ARB_RR_EN: LSU then IFU (last_grant=IFU after reset).
4. Timeout with TIMEOUT_CYC=4 and no mem_rsp_valid -> owner rsp_valid=1, err=1, rdata=0 exactly 4 cycles after entering RSP; a mem_rsp_valid arriving 2 cycles later is ignored.
5. rst_b asserted low while in RSP -> all outputs 0 immediately (asynchronous); after release, the IFU request at 0x80000000 proceeds normally and no stale response appears.
6. mem_rsp_valid and timeout expiry in the same cycle -> err=0 and rdata = mem_rsp_rdata.
